// File: rtl/bus_xfer_ctrl.sv
// Register-transfer micro-sequencer: one request at a time, MOVE / ALU (optionally WIDE) sequencing.
// Optional WIDE result transfer enabled by defining XFER_WIDE_RESULT_EN.
module bus_xfer_ctrl #(
    parameter int XFER_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [4:0]        req_src_a,
    input  logic [4:0]        req_src_b,
    input  logic [4:0]        req_dst,
    input  logic [OP_W-1:0]   req_alu_op,
    output logic [XFER_W-1:0] bus_sel,
    output logic [XFER_W-1:0] dst_en,
    output logic              y_in,
    output logic              z_in,
    output logic              alu_go,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd5;
`ifdef XFER_WIDE_RESULT_EN
    localparam logic [2:0] ST_T4   = 3'd4;
    localparam logic [1:0] K_WIDE  = 2'd2;
    localparam logic [4:0] CODE_HI  = 5'd16;
    localparam logic [4:0] CODE_LO  = 5'd17;
    localparam logic [4:0] CODE_ZHI = 5'd18;
`endif
    localparam logic [1:0] K_MOVE  = 2'd0;
    localparam logic [1:0] K_ALU   = 2'd1;
    localparam logic [4:0] CODE_ZLO = 5'd19;

    logic [2:0]      state;
    logic [1:0]      kind_q;
    logic [4:0]      src_a_q;
    logic [4:0]      src_b_q;
    logic [4:0]      dst_q;
    logic [OP_W-1:0] op_q;
    logic            req_legal;

    function automatic logic src_ok(input logic [4:0] code);
        return code < 5'd24;
    endfunction

    function automatic logic dst_ok(input logic [4:0] code);
        return (code <= 5'd17) || (code == 5'd20) || (code == 5'd24) || (code == 5'd25);
    endfunction

    function automatic logic [XFER_W-1:0] onehot(input logic [4:0] code);
        logic [XFER_W-1:0] v;
        v = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    assign req_ready = (state == ST_IDLE) && !clr;

    always_comb begin
        req_legal = 1'b0;
        case (req_kind)
            K_MOVE:  req_legal = src_ok(req_src_a) && dst_ok(req_dst);
            K_ALU:   req_legal = src_ok(req_src_a) && src_ok(req_src_b) && dst_ok(req_dst);
`ifdef XFER_WIDE_RESULT_EN
            K_WIDE:  req_legal = src_ok(req_src_a) && src_ok(req_src_b);
`endif
            default: req_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_IDLE;
            kind_q  <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            op_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        kind_q  <= req_kind;
                        src_a_q <= req_src_a;
                        src_b_q <= req_src_b;
                        dst_q   <= req_dst;
                        op_q    <= req_alu_op;
                        state   <= req_legal ? ST_T1 : ST_ERR;
                    end
                end
                ST_T1:   state <= (kind_q == K_MOVE) ? ST_IDLE : ST_T2;
                ST_T2:   state <= ST_T3;
`ifdef XFER_WIDE_RESULT_EN
                ST_T3:   state <= (kind_q == K_WIDE) ? ST_T4 : ST_IDLE;
                ST_T4:   state <= ST_IDLE;
`else
                ST_T3:   state <= ST_IDLE;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All outputs come from state and captured fields only.
    always_comb begin
        bus_sel = '0;
        dst_en  = '0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        alu_go  = 1'b0;
        alu_op  = '0;
        done    = 1'b0;
        err     = 1'b0;
        busy    = (state != ST_IDLE);
        case (state)
            ST_T1: begin
                bus_sel = onehot(src_a_q);
                alu_op  = op_q;
                if (kind_q == K_MOVE) begin
                    dst_en = onehot(dst_q);
                    done   = 1'b1;
                end else begin
                    y_in = 1'b1;
                end
            end
            ST_T2: begin
                bus_sel = onehot(src_b_q);
                alu_op  = op_q;
                z_in    = 1'b1;
                alu_go  = 1'b1;
            end
            ST_T3: begin
                bus_sel = onehot(CODE_ZLO);
                alu_op  = op_q;
`ifdef XFER_WIDE_RESULT_EN
                if (kind_q == K_WIDE) begin
                    dst_en = onehot(CODE_LO);
                end else begin
                    dst_en = onehot(dst_q);
                    done   = 1'b1;
                end
`else
                dst_en = onehot(dst_q);
                done   = 1'b1;
`endif
            end
`ifdef XFER_WIDE_RESULT_EN
            ST_T4: begin
                bus_sel = onehot(CODE_ZHI);
                dst_en  = onehot(CODE_HI);
                alu_op  = op_q;
                done    = 1'b1;
            end
`endif
            ST_ERR: begin
                err  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed cases plus randomized traffic against a
// per-request expected-cycle queue model.
module tb_bus_xfer_ctrl;

    localparam int XW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_kind;
    logic [4:0]    req_src_a;
    logic [4:0]    req_src_b;
    logic [4:0]    req_dst;
    logic [OW-1:0] req_alu_op;
    logic [XW-1:0] bus_sel;
    logic [XW-1:0] dst_en;
    logic          y_in;
    logic          z_in;
    logic          alu_go;
    logic [OW-1:0] alu_op;
    logic          busy;
    logic          done;
    logic          err;

    bus_xfer_ctrl #(.XFER_W(XW), .OP_W(OW)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_src_a(req_src_a), .req_src_b(req_src_b),
        .req_dst(req_dst), .req_alu_op(req_alu_op), .bus_sel(bus_sel),
        .dst_en(dst_en), .y_in(y_in), .z_in(z_in), .alu_go(alu_go),
        .alu_op(alu_op), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // strb = {y_in, z_in, alu_go, busy, done, err}
    typedef struct packed {
        logic [31:0] bus;
        logic [31:0] dst;
        logic [5:0]  strb;
        logic [3:0]  op;
    } cyc_t;

    cyc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   last_acc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit src_ok(input int c);
        return c < 24;
    endfunction

    function automatic bit dst_ok(input int c);
        return (c <= 17) || (c == 20) || (c == 24) || (c == 25);
    endfunction

    function automatic logic [31:0] bit_at(input int c);
        return 32'd1 << c;
    endfunction

    // Expected per-cycle behaviour of one accepted request.
    task automatic model_push(input int k, input int a, input int b, input int d, input int op);
        bit wide_on;
        bit legal;
        logic [3:0] o;
`ifdef XFER_WIDE_RESULT_EN
        wide_on = 1'b1;
`else
        wide_on = 1'b0;
`endif
        o = op[3:0];
        case (k)
            0:       legal = src_ok(a) && dst_ok(d);
            1:       legal = src_ok(a) && src_ok(b) && dst_ok(d);
            2:       legal = wide_on && src_ok(a) && src_ok(b);
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            exp_q.push_back('{32'd0, 32'd0, 6'b000111, 4'd0});
        end else if (k == 0) begin
            exp_q.push_back('{bit_at(a), bit_at(d), 6'b000110, o});
        end else begin
            exp_q.push_back('{bit_at(a), 32'd0, 6'b100100, o});
            exp_q.push_back('{bit_at(b), 32'd0, 6'b011100, o});
            if (k == 1) begin
                exp_q.push_back('{bit_at(19), bit_at(d), 6'b000110, o});
            end else begin
                exp_q.push_back('{bit_at(19), bit_at(17), 6'b000100, o});
                exp_q.push_back('{bit_at(18), bit_at(16), 6'b000110, o});
            end
        end
    endtask

    // Called #1 after a rising edge: checks the current cycle, then advances one edge.
    task automatic tick();
        cyc_t e;
        bit   acc;
        int   k, a, b, d, op;
        #2;
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        check_val("bus_sel", bus_sel, e.bus);
        check_val("dst_en", dst_en, e.dst);
        check_val("strobes", {y_in, z_in, alu_go, busy, done, err}, e.strb);
        check_val("alu_op", alu_op, e.op);
        check_val("req_ready", req_ready, (exp_q.size() == 0) && !clr);
        check_val("bus_onehot", $countones(bus_sel) <= 1, 1);
        check_val("dst_onehot", $countones(dst_en) <= 1, 1);
        acc = req_valid && !clr && (exp_q.size() == 0);
        k = req_kind; a = req_src_a; b = req_src_b; d = req_dst; op = req_alu_op;
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) model_push(k, a, b, d, op);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic set_fields(input int k, input int a, input int b, input int d, input int op);
        req_kind   = k[1:0];
        req_src_a  = a[4:0];
        req_src_b  = b[4:0];
        req_dst    = d[4:0];
        req_alu_op = op[3:0];
    endtask

    task automatic scramble();
        set_fields($urandom % 4, $urandom % 32, $urandom % 32, $urandom % 32, $urandom % 16);
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check_val("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) check_val("drain_timeout", 0, 1);
        tick();
    endtask

    task automatic send(input int k, input int a, input int b, input int d, input int op);
        int n;
        req_valid = 1'b1;
        set_fields(k, a, b, d, op);
        wait_accept(n);
        req_valid = 1'b0;
        scramble();
        drain();
    endtask

    function automatic int rand_dst();
        int r;
        if ($urandom % 8 == 0) return $urandom % 32;
        r = $urandom % 21;
        return (r < 18) ? r : (r == 18) ? 20 : (r == 19) ? 24 : 25;
    endfunction

    function automatic int rand_src();
        return ($urandom % 8 == 0) ? ($urandom % 32) : ($urandom % 24);
    endfunction

    initial begin
        int n;
        clr = 1'b1;
        req_valid = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        tick();
        clr = 1'b0;
        tick();

        // Reset during an ALU request sitting in T2
        req_valid = 1'b1;
        set_fields(1, 3, 4, 7, 2);
        wait_accept(n);
        req_valid = 1'b0;
        tick();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        clr = 1'b0;
        tick();
        tick();

        send(0, 5, 0, 20, 1);
        send(1, 3, 4, 7, 2);
        send(0, 26, 0, 3, 0);
        send(0, 2, 0, 21, 0);
        send(0, 9, 0, 9, 5);
        send(2, 6, 8, 0, 7);
        send(3, 1, 1, 1, 1);
        send(1, 0, 23, 25, 15);

        // Back-to-back MOVEs with req_valid held high
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_fields(0, $urandom % 24, 0, $urandom % 18, $urandom % 16);
            wait_accept(n);
            if (i > 0) check_val("b2b_gap", n, 2);
        end
        req_valid = 1'b0;
        drain();

        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom % 3) != 0;
            set_fields($urandom % 4, rand_src(), rand_src(), rand_dst(), $urandom % 16);
            clr = ($urandom % 50) == 0;
            tick();
        end
        clr = 1'b0;
        req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Micro-sequencer for the 32-bit bus datapath: accepts one register-transfer request at a time over a valid/ready handshake and drives the bus-source one-hot (encoder input), the destination load enables and the Y/Z/ALU strobes cycle by cycle. A request is either a single-cycle MOVE or a three-step ALU transfer (A→Y, B→Z, ZLO→dst). It sits between the control unit and the register file/bus mux, replacing hand-driven `Rin`/`Rout` signals.

## Interface

- `XFER_W`, default 32: bus-select and destination-enable vector width; must be ≥26.
- `OP_W`, default 4: ALU operation code width.

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; `req_ready = (state==IDLE) && !clr`.
- `req_kind`  in  2  0=MOVE, 1=ALU, 2=WIDE, 3=illegal.
- `req_src_a`  in  5  first source code.
- `req_src_b`  in  5  second source code (ALU/WIDE only).
- `req_dst`  in  5  destination code.
- `req_alu_op`  in  OP_W  ALU operation, captured on accept.
- `bus_sel`  out  XFER_W  one-hot source driving the encoder; all-zero means no driver.
- `dst_en`  out  XFER_W  one-hot destination load enable.
- `y_in`  out  1  load Y from bus.
- `z_in`  out  1  load Z (HI/LO pair) from ALU.
- `alu_go`  out  1  one-cycle ALU start.
- `alu_op`  out  OP_W  captured op, held from T1 until return to IDLE.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse in the final cycle of a request.
- `err`  out  1  one-cycle pulse, request rejected.

## Operation

- Source codes: 0–15 = R0–R15, 16 = HI, 17 = LO, 18 = ZHI, 19 = ZLO, 20 = PC, 21 = MDR, 22 = InPort, 23 = C_sign_extend. Codes 24–31 are illegal as sources.
- Destination codes: 0–17, 20 (PC), 24 (IR), 25 (MAR). All other codes are illegal as destinations.
- Accept occurs at a rising edge with `req_valid && req_ready`. All request fields are captured into internal flops at that edge, so inputs may change afterwards.
- States: IDLE, T1, T2, T3, T4, ERR.
- Illegal request, IDLE→ERR: any code used by the kind is illegal, or `req_kind`=3, or WIDE with the macro off. In ERR: `err`=1, `done`=1, all enables 0. ERR→IDLE.
- MOVE: T1 drives `bus_sel[src_a]`=1 and `dst_en[dst]`=1, with `done`=1. T1→IDLE.
- ALU, T1: `bus_sel[src_a]`, `y_in`=1.
- ALU, T2: `bus_sel[src_b]`, `z_in`=1, `alu_go`=1.
- ALU, T3: `bus_sel[19]` (ZLO), `dst_en[dst]`, `done`=1. T3→IDLE.
- WIDE: T1 and T2 as ALU; `req_dst` is ignored and not checked.
  - T3: `bus_sel[19]`, `dst_en[17]` (LO).
  - T4: `bus_sel[18]`, `dst_en[16]` (HI), `done`=1. T4→IDLE.
- Outputs are decoded only from state and captured flops; there is no input-to-output combinational path except `clr` into `req_ready`.
- At most one bit of `bus_sel` is set and at most one bit of `dst_en` is set, in every cycle.
- `src_a == dst` is legal; the register reads and reloads itself.

## Timing

- Reset: while `clr`=1 and in the cycle after, state is IDLE and all outputs are 0 (`req_ready` is 0 during `clr`). `alu_op` resets to 0.
- Accept at edge k puts T1 in cycle k+1.
- MOVE occupies 1 cycle, ALU 3, WIDE 4, ERR 1.
- `req_ready` returns high in the cycle after `done`. Maximum throughput is one MOVE per 2 cycles.
- `clr` mid-request aborts at the next edge: no further enables, no `done`, captured request discarded.
- `req_valid` dropping while `req_ready`=0 has no effect.

## Configuration

- `XFER_WIDE_RESULT_EN` defined: WIDE kind supported, with the T4 state as above.
- `XFER_WIDE_RESULT_EN` undefined: T4 is not synthesized, and `req_kind`=2 takes the ERR path (`err`+`done` pulse, no transfers).

## Test plan

- Reset: hold `clr` for 3 cycles during an ALU request in T2. Required: all outputs 0 the cycle after the reset edge, and `req_ready`=1 once `clr`=0.
- MOVE src=5, dst=20 accepted at edge k. Required in cycle k+1: `bus_sel`=0x20, `dst_en`=0x100000, `done`=1. Required in cycle k+2: `req_ready`=1.
- ALU src_a=3, src_b=4, dst=7, op=0x2. Required sequence:
  - T1: `bus_sel`=0x8, `y_in`=1.
  - T2: `bus_sel`=0x10, `z_in`=1, `alu_go`=1.
  - T3: `bus_sel`=0x80000, `dst_en`=0x80, `done`=1.
  - `alu_op`=2 throughout.
- Illegal requests: MOVE src=26, then MOVE dst=21. Required for each: exactly one cycle with `err`=1, `done`=1, `bus_sel`=`dst_en`=0.
- WIDE with macro on: T3 has `dst_en`=0x20000 with `bus_sel`=0x80000, T4 has `dst_en`=0x10000 with `bus_sel`=0x40000. With macro off, WIDE produces an `err` pulse only.
- Back-to-back: `req_valid` held high with 4 queued MOVEs. Required: accepted on every other edge, and no cycle with more than one `bus_sel` or `dst_en` bit set.
